// File: rtl/ikaopll_bus_writer.sv
// Host-side write initiator for the OPLL CPU port: queues {addr,data} pairs and
// replays each as an address bus cycle then a data bus cycle, paced by phiM ticks.
module ikaopll_bus_writer #(
   parameter int unsigned FIFO_AW    = 2,
   parameter int unsigned STROBE_LEN = 2,
   parameter int unsigned ADDR_WAIT  = 12,
   parameter int unsigned DATA_WAIT  = 84
) (
   input  logic               i_EMUCLK,
   input  logic               i_RST,
   input  logic               i_phiM_PCEN_n,
   input  logic               i_CMD_VALID,
   output logic               o_CMD_READY,
   input  logic [7:0]         i_CMD_ADDR,
   input  logic [7:0]         i_CMD_DATA,
   output logic               o_CS_n,
   output logic               o_WR_n,
   output logic               o_A0,
   output logic [7:0]         o_D,
   output logic               o_BUSY,
   output logic [FIFO_AW:0]   o_FIFO_LEVEL,
   output logic               o_DONE_STRB
);

   localparam int unsigned DEPTH = 32'd1 << FIFO_AW;
   localparam int unsigned LW    = FIFO_AW + 1;
   localparam int unsigned CW    = 8;

   // Zero-length phases are clamped to one tick.
   localparam int unsigned STROBE_N = (STROBE_LEN == 0) ? 32'd1 : STROBE_LEN;
   localparam int unsigned AWAIT_N  = (ADDR_WAIT  == 0) ? 32'd1 : ADDR_WAIT;
   localparam int unsigned DWAIT_N  = (DATA_WAIT  == 0) ? 32'd1 : DATA_WAIT;

   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_N - 32'd1);
   localparam logic [CW-1:0] AWAIT_LD  = CW'(AWAIT_N  - 32'd1);
   localparam logic [CW-1:0] DWAIT_LD  = CW'(DWAIT_N  - 32'd1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ADDR_SETUP  = 3'd1,
      ST_ADDR_STROBE = 3'd2,
      ST_ADDR_WAIT   = 3'd3,
      ST_DATA_SETUP  = 3'd4,
      ST_DATA_STROBE = 3'd5,
      ST_DATA_WAIT   = 3'd6
   } state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   cmd_t                 r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]        r_level, w_level_nxt;
   cmd_t                 r_hold, w_hold_nxt;

   logic                 w_tick, w_full, w_push, w_pop, w_done_nxt;
   logic                 w_strobe_n_nxt, w_a0_nxt;
   logic [7:0]           w_d_nxt;

   logic                 r_cs_n, r_wr_n, r_a0, r_busy, r_done;
   logic [7:0]           r_d;

   assign w_tick      = ~i_phiM_PCEN_n;
   assign w_full      = (r_level == LW'(DEPTH));
   assign o_CMD_READY = ~w_full & ~i_RST;
   assign w_push      = i_CMD_VALID & o_CMD_READY;
   assign w_hold_nxt  = w_pop ? r_mem[r_rd_ptr] : r_hold;

   // FIFO storage
   always_ff @(posedge i_EMUCLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_CMD_ADDR, i_CMD_DATA};
      end
   end

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         r_level <= w_level_nxt;
      end
   end

   // FSM state register
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // Next state: each timed phase exits on the tick where the counter reads 0
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_done_nxt  = 1'b0;
      if (w_tick) begin
         if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
         case (r_state)
            ST_IDLE: begin
               if (r_level != '0) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_ADDR_SETUP;
                  w_cnt_nxt   = '0;
               end
            end
            ST_ADDR_SETUP: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_ADDR_STROBE;
                  w_cnt_nxt   = STROBE_LD;
               end
            end
            ST_ADDR_STROBE: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_ADDR_WAIT;
                  w_cnt_nxt   = AWAIT_LD;
               end
            end
            ST_ADDR_WAIT: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_DATA_SETUP;
                  w_cnt_nxt   = '0;
               end
            end
            ST_DATA_SETUP: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_DATA_STROBE;
                  w_cnt_nxt   = STROBE_LD;
               end
            end
            ST_DATA_STROBE: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_DATA_WAIT;
                  w_cnt_nxt   = DWAIT_LD;
               end
            end
            ST_DATA_WAIT: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Bus drive for the state being entered; A0/D only move while strobe is high
   always_comb begin
      w_strobe_n_nxt = 1'b1;
      w_a0_nxt       = 1'b0;
      w_d_nxt        = '0;
      case (w_state_nxt)
         ST_ADDR_SETUP, ST_ADDR_WAIT: begin
            w_d_nxt = w_hold_nxt.addr;
         end
         ST_ADDR_STROBE: begin
            w_strobe_n_nxt = 1'b0;
            w_d_nxt        = w_hold_nxt.addr;
         end
         ST_DATA_SETUP, ST_DATA_WAIT: begin
            w_a0_nxt = 1'b1;
            w_d_nxt  = w_hold_nxt.data;
         end
         ST_DATA_STROBE: begin
            w_strobe_n_nxt = 1'b0;
            w_a0_nxt       = 1'b1;
            w_d_nxt        = w_hold_nxt.data;
         end
         default: begin
            w_strobe_n_nxt = 1'b1;
         end
      endcase
   end

   // Output registers: bus pins move only on ticks, status every clock
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         r_cs_n <= 1'b1;
         r_wr_n <= 1'b1;
         r_a0   <= 1'b0;
         r_d    <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (w_tick) begin
            r_cs_n <= w_strobe_n_nxt;
            r_wr_n <= w_strobe_n_nxt;
            r_a0   <= w_a0_nxt;
            r_d    <= w_d_nxt;
         end
         r_done <= w_done_nxt;
         r_busy <= (w_state_nxt != ST_IDLE) | (w_level_nxt != '0);
      end
   end

   assign o_CS_n       = r_cs_n;
   assign o_WR_n       = r_wr_n;
   assign o_A0         = r_a0;
   assign o_D          = r_d;
   assign o_BUSY       = r_busy;
   assign o_FIFO_LEVEL = r_level;
   assign o_DONE_STRB  = r_done;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Scoreboard bench for ikaopll_bus_writer: default-timing instance A and a
// minimum-timing instance B (all phases one tick).
module tb_ikaopll_bus_writer;

   logic       clk, rst, pcen_n;
   logic       va, vb;
   logic [7:0] aa, da, ab, dbi;
   logic       rdy_a, cs_a, wr_a, a0_a, busy_a, done_a;
   logic       rdy_b, cs_b, wr_b, a0_b, busy_b, done_b;
   logic [7:0] d_a, d_b;
   logic [2:0] lvl_a, lvl_b;

   int n_checks = 0;
   int n_errors = 0;
   int tick_div = 1;
   int div_cnt  = 0;
   bit edge_tick = 0;
   int lvl_at_accept = 0;
   int writes_seen = 0, writes_seen_b = 0, done_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_qb[$];

   logic       cs_h[600], wr_h[600], a0_h[600], done_h[600], busy_h[600], tick_h[600];
   logic [7:0] d_h[600], db_h[600];
   logic       a0b_h[600], doneb_h[600];

   ikaopll_bus_writer u_dut_a (
      .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
      .i_CMD_VALID(va), .o_CMD_READY(rdy_a), .i_CMD_ADDR(aa), .i_CMD_DATA(da),
      .o_CS_n(cs_a), .o_WR_n(wr_a), .o_A0(a0_a), .o_D(d_a),
      .o_BUSY(busy_a), .o_FIFO_LEVEL(lvl_a), .o_DONE_STRB(done_a)
   );

   ikaopll_bus_writer #(.FIFO_AW(2), .STROBE_LEN(1), .ADDR_WAIT(1), .DATA_WAIT(1)) u_dut_b (
      .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
      .i_CMD_VALID(vb), .o_CMD_READY(rdy_b), .i_CMD_ADDR(ab), .i_CMD_DATA(dbi),
      .o_CS_n(cs_b), .o_WR_n(wr_b), .o_A0(a0_b), .o_D(d_b),
      .o_BUSY(busy_b), .o_FIFO_LEVEL(lvl_b), .o_DONE_STRB(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tick generator: pcen_n low for one clock in every tick_div (never when 0)
   initial begin
      pcen_n = 1'b1;
      forever begin
         @(posedge clk);
         edge_tick = ~pcen_n;
         #1;
         if (tick_div == 0) pcen_n = 1'b1;
         else begin
            div_cnt = (div_cnt + 1 >= tick_div) ? 0 : div_cnt + 1;
            pcen_n  = (div_cnt != 0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Instance A monitor: pops expected pair at each strobe, checks strobe hold
   initial begin
      bit prev = 1'b1;
      logic ca0;
      logic [7:0] cd;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (done_a === 1'b1) done_cnt++;
         chk("a_wr_follows_cs", wr_a, cs_a);
         if (cs_a === 1'b0) begin
            if (prev) begin
               ca0 = a0_a; cd = d_a;
               if (exp_q.size() == 0) chk("a_unexpected_write", 1, 0);
               else if (a0_a === 1'b0) chk("a_addr", d_a, exp_q[0][15:8]);
               else begin
                  e = exp_q.pop_front();
                  chk("a_data", d_a, e[7:0]);
                  writes_seen++;
               end
            end else chk("a_strobe_hold", {a0_a, d_a}, {ca0, cd});
         end
         prev = cs_a;
      end
   end

   // Instance B monitor
   initial begin
      bit prev = 1'b1;
      logic ca0;
      logic [7:0] cd;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (cs_b === 1'b0) begin
            chk("b_wr_follows_cs", wr_b, 0);
            if (prev) begin
               ca0 = a0_b; cd = d_b;
               if (exp_qb.size() == 0) chk("b_unexpected_write", 1, 0);
               else if (a0_b === 1'b0) chk("b_addr", d_b, exp_qb[0][15:8]);
               else begin
                  e = exp_qb.pop_front();
                  chk("b_data", d_b, e[7:0]);
                  writes_seen_b++;
               end
            end else chk("b_strobe_hold", {a0_b, d_b}, {ca0, cd});
         end
         prev = cs_b;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input bit b, input logic [7:0] a, input logic [7:0] dt);
      bit ok = 1'b0;
      if (b) begin vb = 1'b1; ab = a; dbi = dt; end
      else   begin va = 1'b1; aa = a; da = dt; end
      for (int t = 0; t < 2000 && !ok; t++) begin
         if ((b ? rdy_b : rdy_a) === 1'b1) begin
            lvl_at_accept = b ? int'(lvl_b) : int'(lvl_a);
            @(posedge clk);
            ok = 1'b1;
            if (b) exp_qb.push_back({a, dt}); else exp_q.push_back({a, dt});
         end else @(negedge clk);
      end
      @(negedge clk);
      va = 1'b0; vb = 1'b0;
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   task automatic record(input int n);
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         cs_h[k] = cs_a; wr_h[k] = wr_a; a0_h[k] = a0_a; d_h[k] = d_a;
         done_h[k] = done_a; busy_h[k] = busy_a; tick_h[k] = edge_tick;
         a0b_h[k] = a0_b; db_h[k] = d_b; doneb_h[k] = done_b;
      end
   endtask

   task automatic wait_idle(input bit b, input int budget);
      bit ok = 1'b0;
      for (int t = 0; t < budget && !ok; t++) begin
         @(negedge clk);
         if ((b ? busy_b : busy_a) === 1'b0) ok = 1'b1;
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ks, kd, ks2, nlow, ndone, offtick, ws0, dc0;
      bit found;
      rst = 1'b1; va = 1'b0; vb = 1'b0; aa = '0; da = '0; ab = '0; dbi = '0;
      tick_div = 1;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs_a, 1);  chk("rst_wr_n", wr_a, 1);
      chk("rst_a0", a0_a, 0);    chk("rst_d", d_a, 0);
      chk("rst_busy", busy_a, 0); chk("rst_level", lvl_a, 0);
      chk("rst_done", done_a, 0); chk("rst_ready", rdy_a, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", rdy_a, 1);

      // Single write, tick every clock; k = edges after the push edge
      push(0, 8'h10, 8'h55);
      record(110);
      chk("t1_busy_k0", busy_h[0], 1);
      chk("t1_setup", {cs_h[1], a0_h[1], d_h[1]}, {1'b1, 1'b0, 8'h10});
      chk("t1_astrobe2", {cs_h[2], wr_h[2], d_h[2]}, {1'b0, 1'b0, 8'h10});
      chk("t1_astrobe3", cs_h[3], 0);
      chk("t1_await_k4", cs_h[4], 1);
      chk("t1_await_k15", {cs_h[15], a0_h[15], d_h[15]}, {1'b1, 1'b0, 8'h10});
      chk("t1_dsetup_k16", {cs_h[16], a0_h[16], d_h[16]}, {1'b1, 1'b1, 8'h55});
      chk("t1_dstrobe17", {cs_h[17], a0_h[17], d_h[17]}, {1'b0, 1'b1, 8'h55});
      chk("t1_dstrobe18", cs_h[18], 0);
      chk("t1_dwait_k19", cs_h[19], 1);
      chk("t1_dwait_k102", {done_h[102], busy_h[102], a0_h[102], d_h[102]}, {1'b0, 1'b1, 1'b1, 8'h55});
      chk("t1_done_k103", {done_h[103], busy_h[103], cs_h[103], a0_h[103], d_h[103]},
          {1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
      chk("t1_done_k104", done_h[104], 0);
      nlow = 0;
      for (int k = 0; k < 110; k++) if (cs_h[k] === 1'b0) nlow++;
      chk("t1_strobe_clocks", nlow, 4);

      // Tick every 4th clock
      tick_div = 4;
      repeat (4) @(negedge clk);
      push(0, 8'h21, 8'h3C);
      record(520);
      ks = -1; kd = -1; ndone = 0; offtick = 0;
      for (int k = 0; k < 520; k++) begin
         if (ks < 0 && a0_h[k] === 1'b0 && d_h[k] === 8'h21) ks = k;
         if (kd < 0 && done_h[k] === 1'b1) kd = k;
         if (done_h[k] === 1'b1) ndone++;
         if (k > 0 && !tick_h[k] &&
             ({cs_h[k], wr_h[k], a0_h[k], d_h[k]} !== {cs_h[k-1], wr_h[k-1], a0_h[k-1], d_h[k-1]} ||
              (done_h[k] === 1'b1 && done_h[k-1] === 1'b0)))
            offtick++;
      end
      chk("t2_setup_found", ks >= 0, 1);
      chk("t2_setup_to_done_clocks", kd - ks, 408);
      chk("t2_done_width_clocks", ndone, 1);
      chk("t2_offtick_changes", offtick, 0);
      wait_idle(0, 100);

      // Fill FIFO with no ticks, then release; a full-FIFO pop must not admit a push
      tick_div = 0;
      @(negedge clk);
      ws0 = writes_seen;
      for (int i = 0; i < 4; i++) begin
         push(0, 8'h40 + 8'(i), 8'h80 + 8'(i));
         chk("t3_level_fill", lvl_a, i + 1);
      end
      chk("t3_ready_full", rdy_a, 0);
      tick_div = 1;
      push(0, 8'h44, 8'h84);
      chk("t3_level_after_pop", lvl_at_accept, 3);
      chk("t3_level_after_push5", lvl_a, 4);
      wait_idle(0, 800);
      chk("t3_writes_on_bus", writes_seen - ws0, 5);
      chk("t3_queue_drained", exp_q.size(), 0);

      // Reset during the data strobe with a second entry queued
      push(0, 8'h20, 8'h66);
      push(0, 8'h21, 8'h67);
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
         if (cs_a === 1'b0 && a0_a === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
      chk("t5_dstrobe_seen", found, 1);
      chk("t5_level_before_rst", lvl_a, 1);
      rst = 1'b1;
      @(negedge clk);
      dc0 = done_cnt;
      chk("t5_rst_bus", {cs_a, wr_a, a0_a, d_a}, {1'b1, 1'b1, 1'b0, 8'h00});
      chk("t5_rst_level", lvl_a, 0);
      chk("t5_rst_busy", busy_a, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (150) @(negedge clk);
      chk("t5_no_done_after_rst", done_cnt - dc0, 0);
      chk("t5_stays_idle", busy_a, 0);
      push(0, 8'h30, 8'h77);
      record(110);
      ks = -1; kd = -1;
      for (int k = 0; k < 110; k++) begin
         if (ks < 0 && a0_h[k] === 1'b0 && d_h[k] === 8'h30) ks = k;
         if (kd < 0 && done_h[k] === 1'b1) kd = k;
      end
      chk("t5_setup_edge", ks, 1);
      chk("t5_full_sequence", kd - ks, 102);

      // Minimum timing instance: 6 ticks per write plus one idle tick
      push(1, 8'h0F, 8'hA5);
      push(1, 8'h1E, 8'hB4);
      record(30);
      ks = -1; kd = -1; ks2 = -1;
      for (int k = 0; k < 30; k++) begin
         if (ks < 0 && a0b_h[k] === 1'b0 && db_h[k] === 8'h0F) ks = k;
         if (ks2 < 0 && a0b_h[k] === 1'b0 && db_h[k] === 8'h1E) ks2 = k;
         if (kd < 0 && doneb_h[k] === 1'b1) kd = k;
      end
      chk("t6_setup_found", ks >= 0, 1);
      chk("t6_setup_to_done", kd - ks, 6);
      chk("t6_write_period", ks2 - ks, 7);
      wait_idle(1, 100);
      chk("t6_writes_on_bus", writes_seen_b, 2);
      chk("t6_queue_drained", exp_qb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
